// File: rtl/pc_fetch_gen.sv
// Fetch PC generator for the IF stage: drives the fetch address and request,
// handshakes with instruction memory, buffers delay-slot branch targets and honours CP0 redirects.
module pc_fetch_gen #(
    parameter int                  ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]   RESET_VECTOR = 32'hBFC00000,
    parameter int                  INC          = 4,
    parameter int                  ALIGN_BITS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              if_ready,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              cp0_branch_flag,
    input  logic [ADDR_W-1:0] cp0_branch_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              misalign_o,
    output logic              redirect_pending_o
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              accept;
    logic [4:0]        stall_unused;

    // Only the IF hold bit matters here; the rest of the stall vector belongs to later stages.
    assign stall_unused = stall[5:1];

    assign misalign_o         = (state_q != S_RESET) && (pc_q[ALIGN_BITS-1:0] != '0);
    assign ce                 = (state_q != S_RESET) && !misalign_o;
    assign accept             = ce && if_ready && !stall[0];
    assign redirect_pending_o = (state_q == S_PEND);
    assign pc                 = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        if (state_q == S_RESET) begin
            state_d = S_RUN;
        end else if (cp0_branch_flag) begin
            // CP0 wins over everything, abandoning any unaccepted request or buffered target.
            pc_d    = cp0_branch_addr;
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (branch_flag_i) begin
                if (accept) begin
                    pc_d = branch_target_address_i;
                end else begin
                    pend_d  = branch_target_address_i;
                    state_d = S_PEND;
                end
            end else if (accept) begin
                pc_d = pc_q + ADDR_W'(INC);
            end
        end else if (accept) begin
            // Delay slot finally accepted: jump to the target captured when the branch arrived.
            pc_d    = pend_q;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: each step drives inputs, queues the expected
// post-edge outputs, and checks them one time unit after the rising edge.
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        if_ready;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        cp0_branch_flag;
    logic [31:0] cp0_branch_addr;
    logic [31:0] pc;
    logic        ce;
    logic        misalign_o;
    logic        redirect_pending_o;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        mis;
        logic        pend;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    pc_fetch_gen dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .if_ready               (if_ready),
        .branch_flag_i          (branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .cp0_branch_flag        (cp0_branch_flag),
        .cp0_branch_addr        (cp0_branch_addr),
        .pc                     (pc),
        .ce                     (ce),
        .misalign_o             (misalign_o),
        .redirect_pending_o     (redirect_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic r, input logic s0, input logic rdy,
                       input logic br, input logic [31:0] tgt,
                       input logic c0, input logic [31:0] caddr);
        rst                     = r;
        stall                   = {5'b0, s0};
        if_ready                = rdy;
        branch_flag_i           = br;
        branch_target_address_i = tgt;
        cp0_branch_flag         = c0;
        cp0_branch_addr         = caddr;
    endtask

    // Queue the expectation for the current inputs, clock once, then compare.
    task automatic step(input logic [31:0] epc, input logic ece, input logic emis,
                        input logic epend, input string tag);
        exp_t e;
        exp_t got;
        e.pc = epc; e.ce = ece; e.mis = emis; e.pend = epend; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        n_cmp++;
        assert (pc === got.pc) else begin
            n_bad++;
            $error("FAIL %s.pc observed=%h expected=%h", got.tag, pc, got.pc);
        end
        n_cmp++;
        assert (ce === got.ce) else begin
            n_bad++;
            $error("FAIL %s.ce observed=%b expected=%b", got.tag, ce, got.ce);
        end
        n_cmp++;
        assert (misalign_o === got.mis) else begin
            n_bad++;
            $error("FAIL %s.misalign observed=%b expected=%b", got.tag, misalign_o, got.mis);
        end
        n_cmp++;
        assert (redirect_pending_o === got.pend) else begin
            n_bad++;
            $error("FAIL %s.pending observed=%b expected=%b", got.tag, redirect_pending_o, got.pend);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drv(1, 0, 1, 0, 32'h0, 0, 32'h0);
        #2;

        // Reset and boot
        for (int i = 0; i < 3; i++) step(32'hBFC00000, 0, 0, 0, "reset");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00000, 1, 0, 0, "boot");
        step(32'hBFC00004, 1, 0, 0, "seq4");
        step(32'hBFC00008, 1, 0, 0, "seq8");
        step(32'hBFC0000C, 1, 0, 0, "seqC");
        step(32'hBFC00010, 1, 0, 0, "seq10");

        // Stall then not-ready holds
        drv(0, 1, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00010, 1, 0, 0, "stall");
        step(32'hBFC00010, 1, 0, 0, "stall");
        drv(0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00010, 1, 0, 0, "notrdy");
        step(32'hBFC00010, 1, 0, 0, "notrdy");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00014, 1, 0, 0, "resume");
        step(32'hBFC00018, 1, 0, 0, "seq18");
        step(32'hBFC0001C, 1, 0, 0, "seq1C");
        step(32'hBFC00020, 1, 0, 0, "seq20");

        // Immediate branch
        drv(0, 0, 1, 1, 32'hBFC00100, 0, 32'h0);
        step(32'hBFC00100, 1, 0, 0, "br_imm");

        // Buffered branch
        drv(0, 0, 1, 0, 32'h0, 1, 32'hBFC00020);
        step(32'hBFC00020, 1, 0, 0, "cp0_back");
        drv(0, 0, 0, 1, 32'hBFC00100, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(32'hBFC00020, 1, 0, 1, "br_buf");
        drv(0, 0, 1, 1, 32'hBFC00100, 0, 32'h0);
        step(32'hBFC00100, 1, 0, 0, "br_release");

        // CP0 beats a pending branch and a stall
        drv(0, 0, 1, 0, 32'h0, 1, 32'hBFC00020);
        step(32'hBFC00020, 1, 0, 0, "cp0_back2");
        drv(0, 0, 0, 1, 32'hBFC00100, 0, 32'h0);
        step(32'hBFC00020, 1, 0, 1, "pend2");
        drv(0, 1, 1, 0, 32'h0, 1, 32'hBFC00380);
        step(32'hBFC00380, 1, 0, 0, "cp0_prio");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00384, 1, 0, 0, "after_cp0");

        // Misaligned fetch, including a branch that arrives while misaligned
        drv(0, 0, 1, 0, 32'h0, 1, 32'hBFC00002);
        step(32'hBFC00002, 0, 1, 0, "misalign");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00002, 0, 1, 0, "mis_hold");
        drv(0, 0, 1, 1, 32'hBFC00100, 0, 32'h0);
        step(32'hBFC00002, 0, 1, 1, "mis_branch");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00002, 0, 1, 1, "mis_pend");
        drv(0, 0, 1, 0, 32'h0, 1, 32'hBFC00380);
        step(32'hBFC00380, 1, 0, 0, "mis_fix");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00384, 1, 0, 0, "mis_next");

        // Address wrap
        drv(0, 0, 1, 0, 32'h0, 1, 32'hFFFFFFFC);
        step(32'hFFFFFFFC, 1, 0, 0, "wrap_top");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'h00000000, 1, 0, 0, "wrap");

        // Reset in S_PEND drops the target and dominates CP0
        drv(0, 0, 0, 1, 32'hBFC00100, 0, 32'h0);
        step(32'h00000000, 1, 0, 1, "pend3");
        drv(1, 0, 1, 1, 32'hBFC00100, 1, 32'hBFC00380);
        step(32'hBFC00000, 0, 0, 0, "rst_pend");
        drv(0, 0, 1, 0, 32'h0, 0, 32'h0);
        step(32'hBFC00000, 1, 0, 0, "reboot");
        step(32'hBFC00004, 1, 0, 0, "reboot_seq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
